fetch_ctrl: RTL

Program-counter and fetch-control stage for the single-cycle CPU. It sits upstream of the ALU: it drives `prog_ctr` into instruction memory and consumes the ALU's `branch_bool` together with the decoder's branch and halt flags. It also owns the 16-entry branch-target lookup table and reports run/done status to the testbench and top level.

---
 rtl/fetch_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Program counter and fetch control: IDLE/RUN/DONE sequencing, branch-target LUT,
// and a saturating retired-instruction counter.
module fetch_ctrl #(
  parameter int unsigned     PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_en,
  input  logic            branch_bool,
  input  logic [3:0]      target_idx,
  input  logic            lut_we,
  input  logic [3:0]      lut_waddr,
  input  logic [PC_W-1:0] lut_wdata,
  output logic [PC_W-1:0] prog_ctr,
  output logic            running,
  output logic            done,
  output logic [15:0]     instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [15:0]     cnt_nxt;
  logic            lut_wr;
  logic [PC_W-1:0] lut [16];

  always_comb begin
    state_nxt = state;
    pc_nxt    = prog_ctr;
    cnt_nxt   = instr_count;
    lut_wr    = 1'b0;
    case (state)
      IDLE, DONE: begin
        lut_wr = lut_we;
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = START_ADDR;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        // Priority: stall > halt > taken branch > sequential increment
        if (!stall) begin
          cnt_nxt = (instr_count == '1) ? instr_count : instr_count + 16'd1;
          if (halt)
            state_nxt = DONE;
          else if (branch_en && branch_bool)
            pc_nxt = lut[target_idx];
          else
            pc_nxt = prog_ctr + PC_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // running/done are registered from the next state so no output is a decode of inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      prog_ctr    <= '0;
      instr_count <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
      lut         <= '{default: '0};
    end else begin
      state       <= state_nxt;
      prog_ctr    <= pc_nxt;
      instr_count <= cnt_nxt;
      running     <= (state_nxt == RUN);
      done        <= (state_nxt == DONE);
      if (lut_wr)
        lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule
